// File: rtl/trace_buffer.sv
// Ping-pong column store between the ray tracer and the VGA renderer.
// The tracer fills the back bank; the renderer reads the front bank and gets a registered wall decision.
module trace_buffer #(
  parameter int COLS       = 640,
  parameter int HEIGHT_MAX = 240,
  parameter int MID_ROW    = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       store,
  input  logic [9:0] column,
  input  logic       side,
  input  logic [7:0] height,
  input  logic       frame_start,
  output logic       tracer_enable,
  input  logic [9:0] rd_col,
  input  logic [9:0] rd_row,
  output logic [7:0] rd_height,
  output logic       rd_side,
  output logic       rd_wall,
  output logic       front_valid,
  output logic       frame_missed
);

  localparam logic STATE_FILL  = 1'b0;
  localparam logic STATE_READY = 1'b1;

  localparam logic [10:0] COLS_W     = 11'(COLS);
  localparam logic [10:0] LAST_COL_W = 11'(COLS - 1);
  localparam logic [10:0] MID_W      = 11'(MID_ROW);
  localparam logic [7:0]  HMAX_W     = 8'(HEIGHT_MAX);

  // Each entry is {side, height}; contents survive reset and are masked by frontValid_q.
  logic [8:0] mem_q [2][COLS];

  logic       state_q, state_d;
  logic       front_q, front_d;
  logic       frontValid_q, frontValid_d;
  logic       tracerEnable_q;
  logic       frameMissed_q;
  logic [7:0] rdHeight_q;
  logic       rdSide_q;
  logic       rdWall_q;

  logic        wrAccept;
  logic [7:0]  wrHeight;
  logic        rdHit;
  logic [8:0]  rdEntry;
  logic [10:0] hExt;
  logic [10:0] rowExt;
  logic        rdWallNext;

  always_comb begin
    wrAccept     = (state_q == STATE_FILL) && store && ({1'b0, column} < COLS_W);
    wrHeight     = (height > HMAX_W) ? HMAX_W : height;
    state_d      = state_q;
    front_d      = front_q;
    frontValid_d = frontValid_q;
    case (state_q)
      STATE_FILL: begin
        if (wrAccept && ({1'b0, column} == LAST_COL_W)) begin
          state_d = STATE_READY;
        end
      end
      STATE_READY: begin
        if (frame_start) begin
          state_d      = STATE_FILL;
          front_d      = ~front_q;
          frontValid_d = 1'b1;
        end
      end
      default: state_d = STATE_FILL;
    endcase
  end

  // Wall span is [MID_ROW-h, MID_ROW+h); 11-bit math keeps MID_ROW+h from wrapping.
  always_comb begin
    rdHit      = frontValid_q && ({1'b0, rd_col} < COLS_W);
    rdEntry    = rdHit ? mem_q[front_q][rd_col] : 9'd0;
    hExt       = {3'b000, rdEntry[7:0]};
    rowExt     = {1'b0, rd_row};
    rdWallNext = (hExt != 11'd0) && (rowExt >= (MID_W - hExt)) && (rowExt < (MID_W + hExt));
  end

  always_ff @(posedge clk) begin
    if (wrAccept && !reset) begin
      mem_q[~front_q][column] <= {side, wrHeight};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= STATE_FILL;
      front_q        <= 1'b0;
      frontValid_q   <= 1'b0;
      tracerEnable_q <= 1'b1;
      frameMissed_q  <= 1'b0;
      rdHeight_q     <= 8'd0;
      rdSide_q       <= 1'b0;
      rdWall_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      front_q        <= front_d;
      frontValid_q   <= frontValid_d;
      tracerEnable_q <= (state_d == STATE_FILL);
      frameMissed_q  <= frame_start && (state_q == STATE_FILL);
      rdHeight_q     <= rdEntry[7:0];
      rdSide_q       <= rdEntry[8];
      rdWall_q       <= rdWallNext;
    end
  end

  assign tracer_enable = tracerEnable_q;
  assign front_valid   = frontValid_q;
  assign frame_missed  = frameMissed_q;
  assign rd_height     = rdHeight_q;
  assign rd_side       = rdSide_q;
  assign rd_wall       = rdWall_q;

endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer: reads are scored through an expectation queue drained by a monitor,
// control outputs are compared right after the sampling edge.
module tb_trace_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       store;
  logic [9:0] column;
  logic       side;
  logic [7:0] height;
  logic       frame_start;
  logic       tracer_enable;
  logic [9:0] rd_col;
  logic [9:0] rd_row;
  logic [7:0] rd_height;
  logic       rd_side;
  logic       rd_wall;
  logic       front_valid;
  logic       frame_missed;

  typedef struct packed {
    logic [9:0] col;
    logic [9:0] row;
    logic [7:0] h;
    logic       s;
    logic       w;
  } rdExp_t;

  rdExp_t expQ[$];
  rdExp_t monE;
  int     checks   = 0;
  int     failures = 0;
  logic   readReq  = 1'b0;
  logic   readLat  = 1'b0;

  always #5 clk = ~clk;

  trace_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .store        (store),
    .column       (column),
    .side         (side),
    .height       (height),
    .frame_start  (frame_start),
    .tracer_enable(tracer_enable),
    .rd_col       (rd_col),
    .rd_row       (rd_row),
    .rd_height    (rd_height),
    .rd_side      (rd_side),
    .rd_wall      (rd_wall),
    .front_valid  (front_valid),
    .frame_missed (frame_missed)
  );

  // A read presented at edge N has its result on the outputs after edge N.
  always @(posedge clk) readLat <= readReq;

  always @(negedge clk) begin
    if (readLat) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL rd_unexpected actual h=%0d s=%0d w=%0d required no pending read",
                 rd_height, rd_side, rd_wall);
      end else begin
        monE = expQ.pop_front();
        if ({rd_height, rd_side, rd_wall} !== {monE.h, monE.s, monE.w}) begin
          failures++;
          $display("[TB] FAIL rd col=%0d row=%0d actual h=%0d s=%0d w=%0d required h=%0d s=%0d w=%0d",
                   monE.col, monE.row, rd_height, rd_side, rd_wall, monE.h, monE.s, monE.w);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [9:0] col, input logic s,
                               input logic [7:0] h, input logic fs);
    store       = st;
    column      = col;
    side        = s;
    height      = h;
    frame_start = fs;
  endtask

  task automatic issueRead(input logic [9:0] c, input logic [9:0] r, input logic [7:0] h,
                           input logic s, input logic w);
    rdExp_t e;
    e.col   = c;
    e.row   = r;
    e.h     = h;
    e.s     = s;
    e.w     = w;
    rd_col  = c;
    rd_row  = r;
    readReq = 1'b1;
    expQ.push_back(e);
  endtask

  task automatic readOne(input logic [9:0] c, input logic [9:0] r, input logic [7:0] h,
                         input logic s, input logic w);
    issueRead(c, r, h, s, w);
    tick();
    readReq = 1'b0;
  endtask

  task automatic pulseFrameStart();
    applyStimulus(1'b0, 10'd0, 1'b0, 8'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 10'd0, 1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    reset  = 1'b1;
    rd_col = 10'd0;
    rd_row = 10'd0;
    applyStimulus(1'b0, 10'd0, 1'b0, 8'd0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    checkOutput("rst_enable", int'(tracer_enable), 1);
    checkOutput("rst_front_valid", int'(front_valid), 0);
    checkOutput("rst_missed", int'(frame_missed), 0);
    checkOutput("rst_rd", int'({rd_height, rd_side, rd_wall}), 0);

    // Full fill, reads masked until the first swap.
    for (int c = 0; c < 640; c++) begin
      applyStimulus(1'b1, 10'(c), c[0], 8'd100, 1'b0);
      if (c == 639) checkOutput("t1_enable_before_last", int'(tracer_enable), 1);
      if (c % 128 == 5) issueRead(10'(c), 10'd140, 8'd0, 1'b0, 1'b0);
      else readReq = 1'b0;
      tick();
    end
    readReq = 1'b0;
    applyStimulus(1'b0, 10'd0, 1'b0, 8'd0, 1'b0);
    checkOutput("t1_enable_fell", int'(tracer_enable), 0);
    checkOutput("t1_front_valid", int'(front_valid), 0);
    applyStimulus(1'b1, 10'd5, 1'b0, 8'd7, 1'b0);
    tick();
    applyStimulus(1'b0, 10'd0, 1'b0, 8'd0, 1'b0);
    checkOutput("t1_ready_enable", int'(tracer_enable), 0);

    pulseFrameStart();
    checkOutput("t2_front_valid", int'(front_valid), 1);
    checkOutput("t2_enable", int'(tracer_enable), 1);
    checkOutput("t2_missed", int'(frame_missed), 0);
    readOne(10'd5, 10'd140, 8'd100, 1'b1, 1'b1);
    readOne(10'd5, 10'd139, 8'd100, 1'b1, 1'b0);
    readOne(10'd5, 10'd339, 8'd100, 1'b1, 1'b1);
    readOne(10'd5, 10'd340, 8'd100, 1'b1, 1'b0);
    readOne(10'd0, 10'd240, 8'd100, 1'b0, 1'b1);
    readOne(10'd639, 10'd200, 8'd100, 1'b1, 1'b1);

    // Partial fill then a premature frame start.
    for (int c = 0; c <= 300; c++) begin
      applyStimulus(1'b1, 10'(c), 1'b0, 8'd50, 1'b0);
      tick();
    end
    pulseFrameStart();
    checkOutput("t3_missed_pulse", int'(frame_missed), 1);
    checkOutput("t3_enable", int'(tracer_enable), 1);
    checkOutput("t3_front_valid", int'(front_valid), 1);
    tick();
    checkOutput("t3_missed_cleared", int'(frame_missed), 0);
    readOne(10'd5, 10'd140, 8'd100, 1'b1, 1'b1);
    readOne(10'd200, 10'd240, 8'd100, 1'b0, 1'b1);

    // Clamp and zero height.
    applyStimulus(1'b1, 10'd10, 1'b1, 8'd250, 1'b0);
    tick();
    applyStimulus(1'b1, 10'd11, 1'b1, 8'd0, 1'b0);
    tick();
    for (int c = 12; c < 640; c++) begin
      applyStimulus(1'b1, 10'(c), 1'b0, 8'd60, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 10'd0, 1'b0, 8'd0, 1'b0);
    checkOutput("t4_enable_fell", int'(tracer_enable), 0);
    pulseFrameStart();
    readOne(10'd10, 10'd0, 8'd240, 1'b1, 1'b1);
    readOne(10'd10, 10'd240, 8'd240, 1'b1, 1'b1);
    readOne(10'd10, 10'd479, 8'd240, 1'b1, 1'b1);
    readOne(10'd10, 10'd480, 8'd240, 1'b1, 1'b0);
    readOne(10'd11, 10'd0, 8'd0, 1'b1, 1'b0);
    readOne(10'd11, 10'd240, 8'd0, 1'b1, 1'b0);
    readOne(10'd11, 10'd479, 8'd0, 1'b1, 1'b0);
    readOne(10'd5, 10'd189, 8'd50, 1'b0, 1'b0);
    readOne(10'd5, 10'd190, 8'd50, 1'b0, 1'b1);
    readOne(10'd5, 10'd289, 8'd50, 1'b0, 1'b1);
    readOne(10'd5, 10'd290, 8'd50, 1'b0, 1'b0);
    readOne(10'd300, 10'd240, 8'd60, 1'b0, 1'b1);

    // Last column coincides with frame start; out-of-range column ignored.
    applyStimulus(1'b1, 10'd700, 1'b0, 8'd33, 1'b0);
    tick();
    checkOutput("t5_col700_no_ready", int'(tracer_enable), 1);
    for (int c = 0; c < 639; c++) begin
      applyStimulus(1'b1, 10'(c), 1'b1, 8'd20, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 10'd639, 1'b1, 8'd20, 1'b1);
    tick();
    applyStimulus(1'b0, 10'd0, 1'b0, 8'd0, 1'b0);
    checkOutput("t5_missed_pulse", int'(frame_missed), 1);
    checkOutput("t5_enable_fell", int'(tracer_enable), 0);
    tick();
    checkOutput("t5_missed_cleared", int'(frame_missed), 0);
    checkOutput("t5_still_ready", int'(tracer_enable), 0);
    readOne(10'd639, 10'd240, 8'd60, 1'b0, 1'b1);
    applyStimulus(1'b0, 10'd0, 1'b0, 8'd0, 1'b1);
    issueRead(10'd639, 10'd240, 8'd60, 1'b0, 1'b1);
    tick();
    readReq = 1'b0;
    applyStimulus(1'b0, 10'd0, 1'b0, 8'd0, 1'b0);
    checkOutput("t5_swap_enable", int'(tracer_enable), 1);
    readOne(10'd0, 10'd230, 8'd20, 1'b1, 1'b1);
    readOne(10'd0, 10'd220, 8'd20, 1'b1, 1'b1);
    readOne(10'd0, 10'd219, 8'd20, 1'b1, 1'b0);
    readOne(10'd639, 10'd259, 8'd20, 1'b1, 1'b1);
    readOne(10'd639, 10'd260, 8'd20, 1'b1, 1'b0);
    readOne(10'd700, 10'd240, 8'd0, 1'b0, 1'b0);

    // Reset mid-fill, then a paced refill holding each column for 32 cycles.
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, 10'(c), 1'b0, 8'd99, 1'b0);
      tick();
    end
    reset = 1'b1;
    applyStimulus(1'b0, 10'd0, 1'b0, 8'd0, 1'b0);
    tick();
    reset = 1'b0;
    checkOutput("t6_front_valid", int'(front_valid), 0);
    checkOutput("t6_enable", int'(tracer_enable), 1);
    checkOutput("t6_missed", int'(frame_missed), 0);
    checkOutput("t6_rd", int'({rd_height, rd_side, rd_wall}), 0);
    readOne(10'd0, 10'd240, 8'd0, 1'b0, 1'b0);
    readOne(10'd639, 10'd240, 8'd0, 1'b0, 1'b0);
    for (int c = 0; c < 640; c++) begin
      applyStimulus(1'b1, 10'(c), c[1], 8'(c), 1'b0);
      repeat (32) tick();
      if (c == 320) checkOutput("t6_enable_mid", int'(tracer_enable), 1);
    end
    applyStimulus(1'b0, 10'd0, 1'b0, 8'd0, 1'b0);
    checkOutput("t6_enable_fell", int'(tracer_enable), 0);
    pulseFrameStart();
    checkOutput("t6_front_valid_after", int'(front_valid), 1);
    checkOutput("t6_enable_after", int'(tracer_enable), 1);
    readOne(10'd0, 10'd240, 8'd0, 1'b0, 1'b0);
    readOne(10'd100, 10'd240, 8'd100, 1'b0, 1'b1);
    readOne(10'd250, 10'd0, 8'd240, 1'b1, 1'b1);
    readOne(10'd639, 10'd113, 8'd127, 1'b1, 1'b1);
    readOne(10'd639, 10'd112, 8'd127, 1'b1, 1'b0);
    readOne(10'd639, 10'd366, 8'd127, 1'b1, 1'b1);
    readOne(10'd639, 10'd367, 8'd127, 1'b1, 1'b0);
    readOne(10'd3, 10'd237, 8'd3, 1'b1, 1'b1);
    readOne(10'd3, 10'd242, 8'd3, 1'b1, 1'b1);
    readOne(10'd3, 10'd243, 8'd3, 1'b1, 1'b0);

    tick();
    tick();
    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
